lsu_nb_queue: RTL
=================

// Module: lsu_nb_queue
// PURPOSE
// Non-blocking load/store unit between execute and the data-cache port. Accepts pre-decoded
// memory ops, issues them in program order with slot tags, and tracks up to DEPTH outstanding
// requests. Memory responses may return out of order; results always retire in program order.
// Supports DEPTH-deep overlap and cache-maintenance ops (flush/invalidate/writeback).
// PARAMETERS
// DEPTH               4             outstanding slots; power of 2, 2..16
// TAG_W               11            mem tag width; tag[log2(DEPTH)-1:0]=slot index, upper bits 0
// MEM_CACHE_ADDR_MIN  32'h00000000  lowest cacheable address (inclusive)
// MEM_CACHE_ADDR_MAX  32'hffffffff  highest cacheable address (inclusive)
// PORTS
// clk_i            in   1      clock
// rst_ni           in   1      asynchronous active-low reset
// req_valid_i      in   1      op valid
// req_ready_o      out  1      op accepted on valid&ready (combinational)
// req_op_i         in   3      0 LOAD, 1 STORE, 2 FLUSH, 3 INVAL, 4 WBACK; 5..7 illegal
// req_size_i       in   2      0 byte, 1 half, 2 word; 3 illegal
// req_signed_i     in   1      sign-extend load result
// req_addr_i       in   32     effective address
// req_wdata_i      in   32     store data, LSB-aligned
// req_rd_i         in   5      destination register
// mem_addr_o       out  32     {addr[31:2],2'b0} for ld/st; full addr for CMO
// mem_data_wr_o    out  32     lane-replicated store data
// mem_rd_o         out  1      read request
// mem_wr_o         out  4      byte write strobes
// mem_flush_o / mem_invalidate_o / mem_writeback_o  out 1 each  CMO request
// mem_cacheable_o  out  1      MIN <= addr <= MAX
// mem_req_tag_o    out  TAG_W  request tag
// mem_accept_i     in   1      request taken this cycle
// mem_ack_i        in   1      response valid
// mem_error_i      in   1      response carries bus error
// mem_resp_tag_i   in   TAG_W  response tag
// mem_data_rd_i    in   32     read data word
// wb_valid_o       out  1      one-cycle retire strobe
// wb_rd_o          out  5      retiring rd; 0 for store/CMO
// wb_value_o       out  32     extended load data; 0 for store/CMO
// wb_exception_o   out  6      0 none, 0x02 illegal, 0x14/0x15 load misalign/fault, 0x16/0x17 store
// stall_o          out  1      req_valid_i & ~req_ready_o
// BEHAVIOUR
// - Reset: slots empty, head=tail=count=0; all registered outputs 0; req_ready_o=1 while in reset.
//   Reset mid-operation discards all slots; later acks find no pending slot and are ignored.
// - req_ready_o = (count<DEPTH) & (~issue_busy | mem_accept_i). Full (count==DEPTH) -> ready=0.
// - Accept at N: allocate slot tail (rd, op, size, signed, addr[1:0]), tail++ modulo DEPTH.
//   Misaligned (half & addr[0]; word & addr[1:0]!=0) or illegal op/size: no mem request, slot
//   done at N+1 with exception (illegal 0x02; misalign load 0x14, store 0x16).
// - Issue: request registers load at N, visible N+1, held stable until mem_accept_i; cleared the
//   cycle after accept unless a new op loads that same cycle (1 op/cycle when accept stays high).
//   Requests leave in program order; no store-to-load forwarding.
// - Store lanes: byte {4{d[7:0]}}, strb 4'b0001<<addr[1:0]; half {2{d[15:0]}}, strb 0011/1100
//   by addr[1]; word strb 1111. Loads: mem_wr_o=0, mem_rd_o=1. CMOs: exactly one CMO strobe.
// - Response: mem_ack_i marks slot tag[..] done, captures data; error -> 0x15 load, 0x17 store/CMO.
//   Ack for a non-pending slot is ignored. Acks may arrive in any order.
// - Retire: if head slot done, wb_* registered valid next cycle, head++; max one retire/cycle.
//   Load data: byte lane addr[1:0], half lane addr[1]; sign- or zero-extend per req_signed_i.
// - Accept and retire in the same cycle: count unchanged. Ack to head at N -> wb_valid_o at N+1.
// - Minimum load latency: accept N, request N+1, ack N+2, wb_valid_o N+3.
// TESTING
// - LB signed addr 0x1001, ack data 0xDEADBEEF -> wb_value_o 0xFFFFFFBE, exc 0, rd echoed.
// - SH addr 0x6002 data 0xBEEF -> mem_addr_o 0x6000, mem_data_wr_o 0xBEEFBEEF, mem_wr_o 1100.
// - LW addr 0x3001 -> no mem_rd_o, wb exc 0x14 one cycle after accept.
// - 4 loads tags 0..3 acked order 3,1,0,2 -> wb order 0,1,2,3; 5th op stalls until first retire.
// - LW ack with mem_error_i -> exc 0x15; FLUSH addr 0x4000 -> mem_flush_o=1, wb_rd_o 0.
// - rst_ni low with 2 pending, late ack after release -> no wb_valid_o, count 0.

Source files
------------

// File: rtl/lsu_nb_queue.sv
// lsu_nb_queue: in-order-issue, out-of-order-completion load/store queue with in-order retire.
// Slot index doubles as the memory tag; rejected ops complete at accept time without a request.
module lsu_nb_queue #(
    parameter int unsigned DEPTH              = 4,
    parameter int unsigned TAG_W              = 11,
    parameter logic [31:0] MEM_CACHE_ADDR_MIN = 32'h00000000,
    parameter logic [31:0] MEM_CACHE_ADDR_MAX = 32'hffffffff
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    input  logic [4:0]       req_rd_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_data_wr_o,
    output logic             mem_rd_o,
    output logic [3:0]       mem_wr_o,
    output logic             mem_flush_o,
    output logic             mem_invalidate_o,
    output logic             mem_writeback_o,
    output logic             mem_cacheable_o,
    output logic [TAG_W-1:0] mem_req_tag_o,
    input  logic             mem_accept_i,
    input  logic             mem_ack_i,
    input  logic             mem_error_i,
    input  logic [TAG_W-1:0] mem_resp_tag_i,
    input  logic [31:0]      mem_data_rd_i,
    output logic             wb_valid_o,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_value_o,
    output logic [5:0]       wb_exception_o,
    output logic             stall_o
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [2:0] OP_LD = 3'd0;
    localparam logic [2:0] OP_ST = 3'd1;

    typedef struct packed {
        logic        vld;
        logic        done;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] data;
        logic [5:0]  exc;
    } slot_t;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    slot_t             rs;
    logic [IW-1:0]     head_q, tail_q, ack_idx;
    logic [IW:0]       count_q;
    logic              busy_q, retire;
    logic [31:0]       mem_addr_q, mem_data_q, wb_value_q, sh, ld_val, st_data;
    logic              mem_rd_q, flush_q, inval_q, wback_q, cache_q, wb_valid_q;
    logic [3:0]        mem_wr_q, st_strb;
    logic [TAG_W-1:0]  tag_q;
    logic [4:0]        wb_rd_q;
    logic [5:0]        wb_exc_q, bad_exc;
    logic              is_ld, is_st, is_cmo, ill, mis, bad, acc, go, ack_hit, cacheable;
    logic [32:0]       lo_d, hi_d;

    assign is_ld   = req_op_i == OP_LD;
    assign is_st   = req_op_i == OP_ST;
    assign is_cmo  = ~is_ld & ~is_st;
    assign ill     = (req_op_i > 3'd4) | (~is_cmo & (req_size_i == 2'd3));
    assign mis     = ~is_cmo & ((req_size_i == 2'd1 & req_addr_i[0]) |
                                (req_size_i == 2'd2 & req_addr_i[1:0] != 2'b00));
    assign bad     = ill | mis;
    assign bad_exc = ill ? 6'h02 : is_ld ? 6'h14 : 6'h16;

    assign req_ready_o = (count_q != (IW+1)'(DEPTH)) & (~busy_q | mem_accept_i);
    assign stall_o     = req_valid_i & ~req_ready_o;
    assign acc         = req_valid_i & req_ready_o;
    assign go          = acc & ~bad;

    assign st_data = req_size_i == 2'd0 ? {4{req_wdata_i[7:0]}} :
                     req_size_i == 2'd1 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
    assign st_strb = req_size_i == 2'd0 ? 4'b0001 << req_addr_i[1:0] :
                     req_size_i == 2'd1 ? (req_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Borrow-out of a 33-bit difference gives the range test without constant-compare corner cases
    assign lo_d      = {1'b0, req_addr_i} - {1'b0, MEM_CACHE_ADDR_MIN};
    assign hi_d      = {1'b0, MEM_CACHE_ADDR_MAX} - {1'b0, req_addr_i};
    assign cacheable = (lo_d < 33'h1_0000_0000) & (hi_d < 33'h1_0000_0000);

    assign ack_idx = mem_resp_tag_i[IW-1:0];
    assign ack_hit = mem_ack_i & ((mem_resp_tag_i >> IW) == '0) &
                     slot_q[ack_idx].vld & ~slot_q[ack_idx].done;

    // Completion and allocation are folded in before the retire check so an ack to the head
    // (or a rejected op landing on an empty queue) retires in the same cycle
    always_comb begin
        slot_d = slot_q;
        if (ack_hit) begin
            slot_d[ack_idx].done = 1'b1;
            slot_d[ack_idx].data = mem_data_rd_i;
            slot_d[ack_idx].exc  = mem_error_i ? (slot_q[ack_idx].op == OP_LD ? 6'h15 : 6'h17) : 6'h00;
        end
        if (acc)
            slot_d[tail_q] = '{vld: 1'b1, done: bad, rd: req_rd_i, op: req_op_i, size: req_size_i,
                               sgn: req_signed_i, off: req_addr_i[1:0], data: 32'h0, exc: bad ? bad_exc : 6'h00};
        rs     = slot_d[head_q];
        retire = rs.vld & rs.done;
        if (retire)
            slot_d[head_q].vld = 1'b0;
    end

    assign sh     = rs.data >> {rs.off, 3'b000};
    assign ld_val = rs.size == 2'd0 ? {{24{rs.sgn & sh[7]}}, sh[7:0]} :
                    rs.size == 2'd1 ? {{16{rs.sgn & sh[15]}}, sh[15:0]} : sh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= '0;
            flush_q    <= 1'b0;
            inval_q    <= 1'b0;
            wback_q    <= 1'b0;
            cache_q    <= 1'b0;
            tag_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_value_q <= '0;
            wb_exc_q   <= '0;
        end else begin
            slot_q     <= slot_d;
            head_q     <= head_q + IW'(retire);
            tail_q     <= tail_q + IW'(acc);
            count_q    <= count_q + (IW+1)'(acc) - (IW+1)'(retire);
            wb_valid_q <= retire;
            if (retire) begin
                wb_rd_q    <= rs.op == OP_LD ? rs.rd : 5'd0;
                wb_value_q <= (rs.op == OP_LD && rs.exc == 6'h00) ? ld_val : 32'h0;
                wb_exc_q   <= rs.exc;
            end
            if (go) begin
                busy_q     <= 1'b1;
                mem_addr_q <= is_cmo ? req_addr_i : {req_addr_i[31:2], 2'b00};
                mem_data_q <= is_st ? st_data : 32'h0;
                mem_rd_q   <= is_ld;
                mem_wr_q   <= is_st ? st_strb : 4'b0000;
                flush_q    <= req_op_i == 3'd2;
                inval_q    <= req_op_i == 3'd3;
                wback_q    <= req_op_i == 3'd4;
                cache_q    <= cacheable;
                tag_q      <= TAG_W'(tail_q);
            end else if (mem_accept_i) begin
                busy_q     <= 1'b0;
                mem_addr_q <= '0;
                mem_data_q <= '0;
                mem_rd_q   <= 1'b0;
                mem_wr_q   <= '0;
                flush_q    <= 1'b0;
                inval_q    <= 1'b0;
                wback_q    <= 1'b0;
                cache_q    <= 1'b0;
                tag_q      <= '0;
            end
        end
    end

    assign mem_addr_o       = mem_addr_q;
    assign mem_data_wr_o    = mem_data_q;
    assign mem_rd_o         = mem_rd_q;
    assign mem_wr_o         = mem_wr_q;
    assign mem_flush_o      = flush_q;
    assign mem_invalidate_o = inval_q;
    assign mem_writeback_o  = wback_q;
    assign mem_cacheable_o  = cache_q;
    assign mem_req_tag_o    = tag_q;
    assign wb_valid_o       = wb_valid_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_value_o       = wb_value_q;
    assign wb_exception_o   = wb_exc_q;
endmodule
